// File: rtl/sha256_block_sequencer.sv
// ============================================================================
// Module      : sha256_block_sequencer
// Description : Sequenced SHA-256 compression controller for pre-padded
//               messages of one or more 512-bit blocks. One compression
//               round per clock, with a rolling 16-word schedule window and
//               chaining state H0..H7 held across blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_block_sequencer #(
    parameter int MAX_BLOCKS = 2,
    parameter int ROUNDS     = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [1:0]                  num_blocks,
    input  logic [0:512*MAX_BLOCKS-1]   padded_message,
    output logic                        ready,
    output logic                        busy,
    output logic                        done,
    output logic [0:255]                digest
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0] c_max_blocks = 3'(MAX_BLOCKS);
    localparam logic [5:0] c_last_round = 6'(ROUNDS - 1);

    localparam logic [31:0] c_iv [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] c_k [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ------------------------------------------------------------------
    // SHA-256 bit-mixing functions (fixed rotate amounts)
    // ------------------------------------------------------------------
    function automatic logic [31:0] f_big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] f_big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] f_small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] f_small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ROUND  = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                      r_state;
    logic [0:512*MAX_BLOCKS-1]   r_msg;
    logic [1:0]                  r_num_blocks;
    logic [1:0]                  r_blk_idx;
    logic [5:0]                  r_t;
    logic [31:0]                 r_h  [0:7];
    logic [31:0]                 r_wv [0:7];   // a..h
    logic [31:0]                 r_w  [0:15];  // rolling schedule window

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic        w_nb_ok;
    logic        w_more_blocks;
    logic [2:0]  w_next_blk;
    logic [31:0] w_t1;
    logic [31:0] w_t2;
    logic [31:0] w_ch;
    logic [31:0] w_maj;
    logic [31:0] w_new_word;
    logic [31:0] w_blk_word [0:15];
    logic [31:0] w_h_sum    [0:7];

    // Request validity and multi-block bookkeeping
    always_comb begin
        w_nb_ok       = (num_blocks != 2'd0) && ({1'b0, num_blocks} <= c_max_blocks);
        w_next_blk    = {1'b0, r_blk_idx} + 3'd1;
        w_more_blocks = (w_next_blk < {1'b0, r_num_blocks});
    end

    // One compression round and the next schedule word
    always_comb begin
        w_ch       = (r_wv[4] & r_wv[5]) ^ (~r_wv[4] & r_wv[6]);
        w_maj      = (r_wv[0] & r_wv[1]) ^ (r_wv[0] & r_wv[2]) ^ (r_wv[1] & r_wv[2]);
        w_t1       = r_wv[7] + f_big_sigma1(r_wv[4]) + w_ch + c_k[r_t] + r_w[0];
        w_t2       = f_big_sigma0(r_wv[0]) + w_maj;
        w_new_word = f_small_sigma1(r_w[14]) + r_w[9] + f_small_sigma0(r_w[1]) + r_w[0];
    end

    // Words of the block currently being compressed
    always_comb begin
        for (int j = 0; j < 16; j++) begin
            w_blk_word[j] = r_msg[512*int'(r_blk_idx) + 32*j +: 32];
        end
    end

    // Chaining-state update after the last round of a block
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_h_sum[i] = r_h[i] + r_wv[i];
        end
    end

    // ------------------------------------------------------------------
    // Controller FSM with registered handshake outputs and datapath state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            ready        <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            digest       <= '0;
            r_t          <= '0;
            r_blk_idx    <= '0;
            r_num_blocks <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start && w_nb_ok) begin
                        r_msg        <= padded_message;
                        r_num_blocks <= num_blocks;
                        r_blk_idx    <= '0;
                        for (int i = 0; i < 8; i++) begin
                            r_h[i] <= c_iv[i];
                        end
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    for (int j = 0; j < 16; j++) begin
                        r_w[j] <= w_blk_word[j];
                    end
                    for (int i = 0; i < 8; i++) begin
                        r_wv[i] <= r_h[i];
                    end
                    r_t     <= '0;
                    r_state <= S_ROUND;
                end

                S_ROUND: begin
                    r_wv[7] <= r_wv[6];
                    r_wv[6] <= r_wv[5];
                    r_wv[5] <= r_wv[4];
                    r_wv[4] <= r_wv[3] + w_t1;
                    r_wv[3] <= r_wv[2];
                    r_wv[2] <= r_wv[1];
                    r_wv[1] <= r_wv[0];
                    r_wv[0] <= w_t1 + w_t2;
                    for (int j = 0; j < 15; j++) begin
                        r_w[j] <= r_w[j+1];
                    end
                    r_w[15] <= w_new_word;
                    r_t     <= r_t + 6'd1;
                    if (r_t == c_last_round) begin
                        r_state <= S_UPDATE;
                    end
                end

                S_UPDATE: begin
                    for (int i = 0; i < 8; i++) begin
                        r_h[i] <= w_h_sum[i];
                    end
                    if (w_more_blocks) begin
                        r_blk_idx <= w_next_blk[1:0];
                        r_state   <= S_LOAD;
                    end else begin
                        // Outputs are registered, so publishing here makes
                        // digest and done visible throughout the DONE cycle.
                        digest  <= {w_h_sum[0], w_h_sum[1], w_h_sum[2], w_h_sum[3],
                                    w_h_sum[4], w_h_sum[5], w_h_sum[6], w_h_sum[7]};
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    done    <= 1'b0;
                    ready   <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    ready   <= 1'b1;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sha256_block_sequencer.sv
// ============================================================================
// Module      : tb_sha256_block_sequencer
// Description : Self-checking bench for sha256_block_sequencer using known
//               vectors, random messages and a behavioural SHA-256 model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sha256_block_sequencer;

    logic           clk;
    logic           reset;
    logic           start;
    logic [1:0]     num_blocks;
    logic [1023:0]  padded_message;
    logic           ready;
    logic           busy;
    logic           done;
    logic [255:0]   digest;

    int n_checks;
    int n_pass;

    sha256_block_sequencer #(.MAX_BLOCKS(2), .ROUNDS(64)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_blocks     (num_blocks),
        .padded_message (padded_message),
        .ready          (ready),
        .busy           (busy),
        .done           (done),
        .digest         (digest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference SHA-256 (textbook form: full 64-word schedule per block)
    // ------------------------------------------------------------------
    localparam logic [31:0] c_k [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_ref(input logic [1023:0] msg, input int nb);
        logic [31:0] h [0:7];
        logic [31:0] v [0:7];
        logic [31:0] w [0:63];
        logic [31:0] t1, t2, s0, s1;
        h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < 16; j++)
                w[j] = msg[1023 - 512*b - 32*j -: 32];
            for (int j = 16; j < 64; j++) begin
                s0 = rotr(w[j-15], 7) ^ rotr(w[j-15], 18) ^ (w[j-15] >> 3);
                s1 = rotr(w[j-2], 17) ^ rotr(w[j-2], 19) ^ (w[j-2] >> 10);
                w[j] = s1 + w[j-7] + s0 + w[j-16];
            end
            for (int i = 0; i < 8; i++) v[i] = h[i];
            for (int t = 0; t < 64; t++) begin
                t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + c_k[t] + w[t];
                t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                   + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                for (int i = 7; i > 0; i--) v[i] = v[i-1];
                v[4] = v[4] + t1;
                v[0] = t1 + t2;
            end
            for (int i = 0; i < 8; i++) h[i] = h[i] + v[i];
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Run one hash; optionally disturb start/inputs while it runs.
    task automatic do_hash(input logic [1023:0] msg, input logic [1:0] nb, input bit disturb,
                           output logic [255:0] dg, output int lat, output int ndone,
                           output bit hs_ok, output bit stable);
        logic [255:0] prev;
        int cyc;
        prev   = digest;
        dg     = '0;
        lat    = -1;
        ndone  = 0;
        hs_ok  = 1'b1;
        stable = 1'b1;
        @(negedge clk);
        padded_message = msg;
        num_blocks     = nb;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc < 400) begin
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = cyc;
                    dg  = digest;
                    if (busy !== 1'b0 || ready !== 1'b0) hs_ok = 1'b0;
                end
            end else if (lat < 0) begin
                if (busy !== 1'b1 || ready !== 1'b0) hs_ok = 1'b0;
                if (digest !== prev) stable = 1'b0;
            end else if (cyc == lat + 1) begin
                if (ready !== 1'b1 || busy !== 1'b0) hs_ok = 1'b0;
            end
            if (disturb) begin
                padded_message = {$urandom, $urandom, padded_message[959:0]};
                if (cyc == 50) begin
                    start      = 1'b1;
                    num_blocks = 2'd1;
                end
                if (cyc == 53) start = 1'b0;
            end
            if (lat >= 0 && cyc >= lat + 4) break;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic hash_check(input string tag, input logic [1023:0] msg, input logic [1:0] nb,
                              input logic [255:0] exp, input bit disturb);
        logic [255:0] dg;
        int lat, ndone;
        bit hs_ok, stable;
        do_hash(msg, nb, disturb, dg, lat, ndone, hs_ok, stable);
        check({tag, " digest"},    dg, exp);
        check({tag, " latency"},   256'(lat), 256'(66 * int'(nb) + 1));
        check({tag, " done_count"}, 256'(ndone), 256'(1));
        check({tag, " handshake"}, {255'b0, hs_ok}, 256'(1));
        check({tag, " digest_hold"}, {255'b0, stable}, 256'(1));
    endtask

    // Present an invalid block count and confirm nothing happens.
    task automatic bad_nb_check(input string tag, input logic [1:0] nb);
        logic [255:0] prev;
        bit quiet;
        prev  = digest;
        quiet = 1'b1;
        @(negedge clk);
        padded_message = {$urandom, $urandom, 960'h0};
        num_blocks     = nb;
        start          = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) quiet = 1'b0;
        end
        start = 1'b0;
        check({tag, " idle"},   {255'b0, quiet}, 256'(1));
        check({tag, " digest"}, digest, prev);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    localparam logic [255:0] c_abc_dg   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] c_empty_dg = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] c_448_dg   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic [1023:0] m_abc, m_empty, m_448, m_rand;
    logic [1:0]    nb_rand;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        num_blocks     = 2'd0;
        padded_message = '0;

        m_abc   = {32'h61626380, 448'h0, 32'h00000018, 512'h0};
        m_empty = {32'h80000000, 448'h0, 32'h00000000, 512'h0};
        m_448   = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                   32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                   32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                   32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000,
                   480'h0, 32'h000001c0};

        repeat (3) @(negedge clk);
        check("rst ready",  {255'b0, ready}, 256'(1));
        check("rst busy",   {255'b0, busy},  256'(0));
        check("rst done",   {255'b0, done},  256'(0));
        check("rst digest", digest, 256'h0);
        reset = 1'b0;

        hash_check("abc",   m_abc,   2'd1, c_abc_dg,   1'b0);
        hash_check("empty", m_empty, 2'd1, c_empty_dg, 1'b0);
        hash_check("two_blk", m_448, 2'd2, c_448_dg,   1'b0);
        hash_check("disturbed", m_448, 2'd2, c_448_dg, 1'b1);

        bad_nb_check("nb0", 2'd0);
        bad_nb_check("nb3", 2'd3);

        // Abort at round 30 of the "abc" hash, then rerun it.
        @(negedge clk);
        padded_message = m_abc;
        num_blocks     = 2'd1;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (32) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort digest", digest, 256'h0);
        check("abort ready",  {255'b0, ready}, 256'(1));
        check("abort done",   {255'b0, done},  256'(0));
        check("abort busy",   {255'b0, busy},  256'(0));
        reset = 1'b0;
        hash_check("rerun", m_abc, 2'd1, c_abc_dg, 1'b0);

        // Random padded-looking messages against the reference model.
        for (int n = 0; n < 6; n++) begin
            for (int j = 0; j < 32; j++) m_rand[1023 - 32*j -: 32] = $urandom;
            nb_rand = 2'($urandom_range(1, 2));
            hash_check($sformatf("rand%0d", n), m_rand, nb_rand, sha_ref(m_rand, int'(nb_rand)), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sha256_block_sequencer.md
Name: sha256_block_sequencer

Overview:
Multi-block SHA-256 compression controller sitting after the padding stage. It accepts an already-padded 1024-bit message of one or two 512-bit blocks and runs one compression round per clock. It owns the chaining state H0..H7, the 16-word rolling message-schedule window, the round counter, and the start/done handshake. It replaces the fully unrolled combinational schedule/compression path with a sequenced, area-bounded one.

Parameters:
- MAX_BLOCKS, 2, maximum number of 512-bit blocks per message; padded_message width = 512*MAX_BLOCKS.
- ROUNDS, 64, compression rounds per block; fixed by SHA-256 and not to be overridden.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to hash; accepted only while ready=1.
- num_blocks  input  2  number of blocks to process (1..MAX_BLOCKS); sampled with start.
- padded_message  input  1024  bits [0:1023]; block 0 = [0:511], block 1 = [512:1023]; word j of a block = bits [32j:32j+31], MSB first; sampled with start.
- ready  output  1  high in IDLE only.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse; digest is valid from this cycle.
- digest  output  256  H0..H7 concatenated, H0 at [0:31]; held until the next accepted start or reset.

Behaviour:
- Reset: state=IDLE, ready=1, busy=0, done=0, digest=0, round counter=0, block index=0. A reset mid-hash aborts immediately; no done pulse.
- States are IDLE, LOAD, ROUND, UPDATE, DONE.
- IDLE:
  - start=1 with 1<=num_blocks<=MAX_BLOCKS: latch padded_message and num_blocks, set H to the SHA-256 IV (6a09e667 ... 5be0cd19), set block index=0, go to LOAD.
  - start with num_blocks=0 or num_blocks>MAX_BLOCKS is ignored and the block stays in IDLE.
- LOAD (1 cycle): W window[0..15] <= words of the current block; a..h <= H0..H7; round counter t=0; go to ROUND.
- ROUND (64 cycles, t=0..63):
  - Wt = window[0].
  - T1 = h+Σ1(e)+Ch(e,f,g)+Kt+Wt, T2 = Σ0(a)+Maj(a,b,c).
  - Update: h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
  - Window shifts down one word; the new word[15] = σ1(w[14])+w[9]+σ0(w[1])+w[0].
  - All additions are mod 2^32; carries are discarded.
  - At t=63, go to UPDATE.
- UPDATE (1 cycle): Hi <= Hi + working variable i (mod 2^32).
  - If block index+1 < num_blocks: increment block index and go to LOAD.
  - Otherwise go to DONE.
- DONE (1 cycle): digest <= updated H, done=1, busy=0; next state is IDLE.
- Latency: with start accepted at edge 0, done is high in cycle 66*num_blocks+1 (67 cycles for 1 block, 133 for 2). ready rises the cycle after done.
- start while busy or in DONE is ignored and has no effect on the running hash.
- Changes to padded_message/num_blocks after acceptance have no effect, because the inputs are latched.
- digest does not change during a hash; it updates only in the DONE cycle. Back-to-back hashes are allowed: start is accepted in the first IDLE cycle after DONE.
- K constants come from a 64-entry constant table indexed by t.

Test Plan:
1. Reset, then hash "abc" padded (message 61626380, zeros, length word 00000018; num_blocks=1) -> done in cycle 67; digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
2. Empty string (80000000, zeros, length 0; num_blocks=1) -> digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
3. 448-bit "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", padded to two blocks, num_blocks=2 -> done in cycle 133; digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
4. Pulse start again mid-hash with different data, and toggle padded_message, during test 3 -> digest unchanged from test 3; a single done pulse.
5. num_blocks=0 and num_blocks=3 with start -> ready stays 1, busy stays 0, no done, digest unchanged.
6. Assert reset at round 30 of test 1, then rerun test 1 -> during the reset cycle, digest=0 and ready=1 with no done; the rerun yields the test 1 digest in 67 cycles.
